// File: rtl/popcount_pkg.sv
// popcount_pkg: shared widths, FSM state type and accumulator sizing helper for popcount_accum
package popcount_pkg;
  localparam int WORD_W = 7;
  localparam int PC_W = 3;
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;
  function automatic int min_acc_w(input int frame_len);
    return $clog2(WORD_W * frame_len + 1);
  endfunction
endpackage

// File: rtl/sum.sv
// sum: 7-input popcount stage, combinational count of set bits
module sum (
  input  logic [6:0] a,
  output logic [2:0] y
);
  always_comb y = 3'(a[0]) + 3'(a[1]) + 3'(a[2]) + 3'(a[3]) + 3'(a[4]) + 3'(a[5]) + 3'(a[6]);
endmodule

// File: rtl/popcount_accum.sv
// popcount_accum: per-frame popcount accumulator with word count; POPCNT_MAX_TRACK_EN adds per-frame max popcount
module popcount_accum
  import popcount_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int ACC_W = 6,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic [PC_W-1:0]   out_max
);
  if (FRAME_LEN < 1 || FRAME_LEN > 255) begin : g_bad_len
    $error("popcount_accum: FRAME_LEN out of range");
  end
  if (ACC_W < min_acc_w(FRAME_LEN)) begin : g_bad_acc
    $error("popcount_accum: ACC_W too narrow for FRAME_LEN");
  end
  if (CNT_W < $clog2(FRAME_LEN + 1)) begin : g_bad_cnt
    $error("popcount_accum: CNT_W too narrow for FRAME_LEN");
  end
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, out_sum_q, out_sum_d, acc_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d, out_count_q, out_count_d, cnt_nxt;
  logic [PC_W-1:0] pc;
  logic accept, frame_end;
  sum u_sum (.a(in_data), .y(pc));
  assign in_ready = state_q == ACCUM;
  assign out_valid = state_q == HOLD;
  assign out_sum = out_sum_q;
  assign out_count = out_count_q;
  always_comb begin
    accept = in_valid && state_q == ACCUM;
    frame_end = accept && (in_last || cnt_q == CNT_W'(FRAME_LEN - 1));
    acc_nxt = acc_q + ACC_W'(pc);
    cnt_nxt = cnt_q + CNT_W'(1);
    acc_d = frame_end ? '0 : accept ? acc_nxt : acc_q;
    cnt_d = frame_end ? '0 : accept ? cnt_nxt : cnt_q;
    out_sum_d = frame_end ? acc_nxt : out_sum_q;
    out_count_d = frame_end ? cnt_nxt : out_count_q;
    state_d = frame_end ? HOLD : (state_q == HOLD && out_ready) ? ACCUM : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q <= '0;
      cnt_q <= '0;
      out_sum_q <= '0;
      out_count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      out_sum_q <= out_sum_d;
      out_count_q <= out_count_d;
    end
  end
`ifdef POPCNT_MAX_TRACK_EN
  logic [PC_W-1:0] max_q, max_d, out_max_q, out_max_d, pc_max;
  assign out_max = out_max_q;
  always_comb begin
    pc_max = pc > max_q ? pc : max_q;
    max_d = frame_end ? '0 : accept ? pc_max : max_q;
    out_max_d = frame_end ? pc_max : out_max_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_q <= '0;
      out_max_q <= '0;
    end else begin
      max_q <= max_d;
      out_max_q <= out_max_d;
    end
  end
`else
  assign out_max = '0;
`endif
endmodule

// File: tb/tb_popcount_accum.sv
// tb_popcount_accum: directed self-checking bench for popcount_accum (FRAME_LEN=8)
module tb_popcount_accum;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [6:0] in_data = '0;
  logic in_ready, out_valid;
  logic [5:0] out_sum;
  logic [3:0] out_count;
  logic [2:0] out_max;
  int vectors = 0, miscompares = 0;
`ifdef POPCNT_MAX_TRACK_EN
  localparam bit MAXEN = 1;
`else
  localparam bit MAXEN = 0;
`endif
  popcount_accum #(.FRAME_LEN(8), .ACC_W(6), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count), .out_max(out_max)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] exp_max(input logic [2:0] m);
    return MAXEN ? m : 3'd0;
  endfunction
  task automatic send(input logic [6:0] d, input logic last);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    in_valid = 1;
    in_data = d;
    in_last = last;
    @(negedge clk);
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic consume();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_hs out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
    end
    vectors++;
    if (out_sum !== 6'd0 || out_count !== 4'd0 || out_max !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_out sum=%0d count=%0d max=%0d required 0/0/0", out_sum, out_count, out_max);
    end
  endtask
  task automatic test_mixed_frame();
    send(7'h7F, 0); send(7'h00, 0); send(7'h55, 0); send(7'h01, 1);
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mixed_valid out_valid=%0b in_ready=%0b required 1/0", out_valid, in_ready);
    end
    vectors++;
    if (out_sum !== 6'd12 || out_count !== 4'd4 || out_max !== exp_max(3'd7)) begin
      miscompares++;
      $display("FAIL mixed_out sum=%0d count=%0d max=%0d required 12/4/%0d", out_sum, out_count, out_max, exp_max(3'd7));
    end
    consume();
  endtask
  task automatic test_full_frame();
    for (int i = 0; i < 8; i++) send(7'h7F, 0);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 6'd56 || out_count !== 4'd8 || out_max !== exp_max(3'd7)) begin
      miscompares++;
      $display("FAIL full_out valid=%0b sum=%0d count=%0d max=%0d required 1/56/8/%0d", out_valid, out_sum, out_count, out_max, exp_max(3'd7));
    end
    consume();
  endtask
  task automatic test_early_last();
    send(7'h03, 0); send(7'h0F, 1);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 6'd6 || out_count !== 4'd2 || out_max !== exp_max(3'd4)) begin
      miscompares++;
      $display("FAIL early_out valid=%0b sum=%0d count=%0d max=%0d required 1/6/2/%0d", out_valid, out_sum, out_count, out_max, exp_max(3'd4));
    end
    consume();
    send(7'h01, 1);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 6'd1 || out_count !== 4'd1 || out_max !== exp_max(3'd1)) begin
      miscompares++;
      $display("FAIL early_next sum=%0d count=%0d max=%0d required 1/1/%0d", out_sum, out_count, out_max, exp_max(3'd1));
    end
    consume();
  endtask
  task automatic test_backpressure();
    send(7'h01, 1);
    in_valid = 1;
    in_data = 7'h7F;
    in_last = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 6'd1 || out_count !== 4'd1) begin
        miscompares++;
        $display("FAIL bp_hold cyc=%0d valid=%0b ready=%0b sum=%0d count=%0d required 1/0/1/1", i, out_valid, in_ready, out_sum, out_count);
      end
    end
    in_valid = 0;
    in_last = 0;
    consume();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
    end
    send(7'h7F, 1);
    vectors++;
    if (out_sum !== 6'd7 || out_count !== 4'd1) begin
      miscompares++;
      $display("FAIL bp_after sum=%0d count=%0d required 7/1", out_sum, out_count);
    end
    consume();
  endtask
  task automatic test_reset_mid_frame();
    send(7'h7F, 0); send(7'h7F, 0); send(7'h7F, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL rst_mid cyc=%0d out_valid=%0b in_ready=%0b required 0/1", i, out_valid, in_ready);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) send(7'h01, i == 3);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 6'd4 || out_count !== 4'd4 || out_max !== exp_max(3'd1)) begin
      miscompares++;
      $display("FAIL rst_next valid=%0b sum=%0d count=%0d max=%0d required 1/4/4/%0d", out_valid, out_sum, out_count, out_max, exp_max(3'd1));
    end
    consume();
  endtask
  task automatic test_simultaneous_end();
    for (int i = 0; i < 8; i++) send(7'h01, i == 7);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 6'd8 || out_count !== 4'd8) begin
      miscompares++;
      $display("FAIL simul_out valid=%0b sum=%0d count=%0d required 1/8/8", out_valid, out_sum, out_count);
    end
    consume();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL simul_spurious cyc=%0d out_valid=%0b required 0", i, out_valid);
      end
      @(negedge clk);
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_mixed_frame();
    test_full_frame();
    test_early_last();
    test_backpressure();
    test_reset_mid_frame();
    test_simultaneous_end();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
